// File: rtl/rr_arbiter_3.sv
// rr_arbiter_3: three-source round-robin arbiter driving a mux_3_1 select.
// The granted source's data is forwarded to one consumer over valid/ready.
// A hold limit forces rotation when another source is waiting.
//
// mux_3_1 ports:
//   n0, n1, n2  [W-1:0] in  : candidate operands
//   sel         [1:0]   in  : operand select (0..2)
//   res         [W-1:0] out : selected operand
//
// rr_arbiter_3 ports:
//   clk              in  : rising-edge clock
//   rst_n            in  : asynchronous active-low reset
//   req      [2:0]   in  : per-source request
//   d0, d1, d2       in  : source data, DATA_W bits each (DATA_W must be 32)
//   gnt      [2:0]   out : registered one-hot grant, zero when idle
//   sel      [1:0]   out : registered mux select, never 3
//   out_data         out : data of the selected source (combinational)
//   out_valid        out : owner is granted and still requesting
//   out_ready        in  : consumer accepts out_data this edge when valid
//   busy             out : arbiter is in GRANT

module mux_3_1 #(
    parameter int W = 32
) (
    input  logic [W-1:0] n0,
    input  logic [W-1:0] n1,
    input  logic [W-1:0] n2,
    input  logic [1:0]   sel,
    output logic [W-1:0] res
);
    always_comb res = (sel == 2'd0) ? n0 : (sel == 2'd1) ? n1 : (sel == 2'd2) ? n2 : '0;
endmodule

module rr_arbiter_3 #(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    output logic [2:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_d;
    logic [2:0]  gnt_d;
    logic [1:0]  sel_d, last, last_d;
    logic [7:0]  hold_cnt, hold_d;
    logic [1:0]  p1, p2, pick;
    logic        xfer, hold_hit, others;

    mux_3_1 #(.W(DATA_W)) u_mux (
        .n0 (d0),
        .n1 (d1),
        .n2 (d2),
        .sel(sel),
        .res(out_data)
    );

    // Priority order starts just after the previous owner, which comes last.
    always_comb begin
        p1   = (last == 2'd2) ? 2'd0 : last + 2'd1;
        p2   = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        pick = req[p1] ? p1 : req[p2] ? p2 : last;
    end

    always_comb begin
        xfer     = out_valid && out_ready;
        hold_hit = ({1'b0, hold_cnt} + 9'd1) == 9'(MAX_HOLD);
        others   = |(req & ~gnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 3'b000;
            sel      <= 2'd0;
            last     <= 2'd2;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            sel      <= sel_d;
            last     <= last_d;
            hold_cnt <= hold_d;
        end
    end

    // sel is left alone on release so it only moves when a new grant is made.
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        sel_d   = sel;
        last_d  = last;
        hold_d  = hold_cnt;
        if (state == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                gnt_d   = 3'b001 << pick;
                sel_d   = pick;
                last_d  = pick;
                hold_d  = 8'd0;
            end
        end else if (!req[sel]) begin
            state_d = IDLE;
            gnt_d   = 3'b000;
        end else if (xfer) begin
            hold_d = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            if (hold_hit && others) begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        end
    end

    always_comb begin
        busy      = state == GRANT;
        out_valid = |(gnt & req);
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_busy:   assert property (@(posedge clk) disable iff (!rst_n) (gnt != 3'b000) == busy);
    a_sel:    assert property (@(posedge clk) disable iff (!rst_n) busy |-> gnt[sel]);
    a_valid:  assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> busy);
endmodule

// File: tb/tb_rr_arbiter_3.sv
// tb_rr_arbiter_3: directed and randomized checks of rr_arbiter_3 against a queue-free behavioural model.
module tb_rr_arbiter_3;
    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [31:0] d0 = '0, d1 = '0, d2 = '0;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Model: owner (-1 = idle), previous winner, select, accepted beats this grant.
    int m_owner = -1;
    int m_last  = 2;
    int m_sel   = 0;
    int m_cnt   = 0;

    rr_arbiter_3 #(.DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .gnt      (gnt),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_gnt();
        return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    endfunction

    function automatic logic exp_valid();
        return (m_owner >= 0) && req[m_owner];
    endfunction

    function automatic logic [31:0] exp_data();
        return (m_sel == 0) ? d0 : (m_sel == 1) ? d1 : d2;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 2;
        m_sel   = 0;
        m_cnt   = 0;
    endtask

    task automatic drive(input logic [2:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        d0        = $urandom;
        d1        = $urandom;
        d2        = $urandom;
        #2;
    endtask

    // One clock edge; the model advances on the inputs that were present at the edge.
    task automatic step();
        @(posedge clk);
        if (m_owner < 0) begin
            if (req != 3'b000) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner;
                m_sel  = m_owner;
                m_cnt  = 0;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (out_ready) begin
            int nxt;
            nxt   = m_cnt + 1;
            m_cnt = (nxt > 255) ? 255 : nxt;
            if (nxt == MAX_HOLD && (req & ~(3'b001 << m_owner)) != 3'b000) m_owner = -1;
        end
        #1;
    endtask

    task automatic do_reset();
        req       = 3'b000;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(3'b111, 1'b1);
        tests++;
        if (gnt !== 3'b000 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset outputs: gnt=%b sel=%0d busy=%b valid=%b, required 000/0/0/0", gnt, sel, busy, out_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset held over edge: gnt=%b busy=%b, required 000/0", gnt, busy);
        end
        req   = 3'b000;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(3'b001, 1'b1);
        tests++;
        if (gnt !== 3'b000) begin
            fails++;
            $display("FAIL single latency: gnt=%b before edge, required 000", gnt);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            drive(3'b001, 1'b1);
            d0 = 32'hAAAA_0000;
            #1;
            tests++;
            if (gnt !== 3'b001 || sel !== 2'd0 || out_valid !== 1'b1 || out_data !== 32'hAAAA_0000) begin
                fails++;
                $display("FAIL single beat %0d: gnt=%b sel=%0d valid=%b data=%h, required 001/0/1/aaaa0000", i, gnt, sel, out_valid, out_data);
            end
            step();
        end
        drive(3'b000, 1'b1);
        step();
    endtask

    task automatic test_rotation();
        do_reset();
        for (int g = 0; g < 4; g++) begin
            logic [2:0] want;
            int beats;
            want  = 3'(1 << (g % 3));
            beats = 0;
            drive(3'b111, 1'b1);
            if (g == 0) step();
            tests++;
            if (gnt !== want) begin
                fails++;
                $display("FAIL rotation grant %0d: gnt=%b, required %b", g, gnt, want);
            end
            for (int i = 0; i < 20 && gnt === want; i++) begin
                drive(3'b111, 1'b1);
                if (out_valid && out_ready) beats++;
                step();
            end
            tests++;
            if (beats != MAX_HOLD) begin
                fails++;
                $display("FAIL rotation beats %0d: got %0d, required %0d", g, beats, MAX_HOLD);
            end
            tests++;
            if (gnt !== 3'b000) begin
                fails++;
                $display("FAIL rotation idle gap %0d: gnt=%b, required 000", g, gnt);
            end
            drive(3'b111, 1'b1);
            step();
        end
        drive(3'b000, 1'b0);
        step();
        step();
    endtask

    task automatic test_lone_requester();
        int beats;
        int bad;
        beats = 0;
        bad   = 0;
        drive(3'b010, 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(3'b010, 1'b1);
            if (gnt !== 3'b010) bad++;
            if (out_valid && out_ready) beats++;
            step();
        end
        tests++;
        if (beats != 20 || bad != 0) begin
            fails++;
            $display("FAIL lone requester: beats=%0d off-grant cycles=%0d, required 20/0", beats, bad);
        end
        drive(3'b000, 1'b1);
        step();
    endtask

    task automatic test_stall();
        int beats;
        beats = 0;
        do_reset();
        drive(3'b001, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(3'b101, 1'b0);
            if (out_valid && out_ready) beats++;
            step();
        end
        tests++;
        if (gnt !== 3'b001 || beats != 0) begin
            fails++;
            $display("FAIL stall hold: gnt=%b beats=%0d, required 001/0", gnt, beats);
        end
        for (int i = 0; i < 20 && gnt === 3'b001; i++) begin
            drive(3'b101, 1'b1);
            if (out_valid && out_ready) beats++;
            step();
        end
        tests++;
        if (beats != MAX_HOLD || gnt !== 3'b000) begin
            fails++;
            $display("FAIL stall release: beats=%0d gnt=%b, required %0d/000", beats, gnt, MAX_HOLD);
        end
        drive(3'b101, 1'b1);
        step();
        tests++;
        if (gnt !== 3'b100 || sel !== 2'd2) begin
            fails++;
            $display("FAIL stall next owner: gnt=%b sel=%0d, required 100/2", gnt, sel);
        end
        drive(3'b000, 1'b0);
        step();
        step();
    endtask

    task automatic test_release();
        do_reset();
        drive(3'b100, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(3'b100, 1'b1);
            step();
        end
        drive(3'b011, 1'b1);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL release valid on drop: valid=%b, required 0", out_valid);
        end
        step();
        tests++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL release idle: gnt=%b busy=%b, required 000/0", gnt, busy);
        end
        drive(3'b011, 1'b1);
        step();
        tests++;
        if (gnt !== 3'b001) begin
            fails++;
            $display("FAIL release next grant: gnt=%b, required 001", gnt);
        end
        drive(3'b000, 1'b0);
        step();
        step();
    endtask

    task automatic test_random();
        logic [2:0] r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 7) == 0) ? r ^ 3'(1 << $urandom_range(0, 2)) : r;
            if (i == 0) r = 3'b000;
            if ($urandom_range(0, 5) == 0) r = 3'($urandom);
            drive(r, 1'($urandom_range(0, 3) != 0));
            tests++;
            if (gnt !== exp_gnt() || busy !== (m_owner >= 0) || sel !== 2'(m_sel) ||
                out_valid !== exp_valid() || out_data !== exp_data()) begin
                fails++;
                $display("FAIL random cycle %0d: gnt=%b busy=%b sel=%0d valid=%b data=%h, required %b/%b/%0d/%b/%h",
                         i, gnt, busy, sel, out_valid, out_data, exp_gnt(), m_owner >= 0, m_sel, exp_valid(), exp_data());
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(3'b111, 1'b1);
        step();
        drive(3'b111, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (gnt !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async reset: gnt=%b valid=%b busy=%b, required 000/0/0", gnt, out_valid, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(3'b111, 1'b1);
        step();
        tests++;
        if (gnt !== 3'b001 || sel !== 2'd0) begin
            fails++;
            $display("FAIL async reset first grant: gnt=%b sel=%0d, required 001/0", gnt, sel);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_lone_requester();
        test_stall();
        test_release();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
